// File: rtl/bridge_ram2bus_if.sv
// OCP-style system bus between the RAM-to-bus bridge (master) and a bus slave.
// Command/response encodings: MCmd IDLE=000 WR=001 RD=010; SResp NULL=00 DVA=01 FAIL=10 ERR=11.
interface bridge_ram2bus_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int NUM_BYTES = DATA_WIDTH / 8;

    logic [2:0]            MCmd;
    logic [ADDR_WIDTH-1:0] MAddr;
    logic [DATA_WIDTH-1:0] MData;
    logic [NUM_BYTES-1:0]  MByteEn;
    logic                  MRespAccept;
    logic                  SCmdAccept;
    logic                  SDataAccept;
    logic [1:0]            SResp;
    logic [DATA_WIDTH-1:0] SData;

    modport master (
        output MCmd, MAddr, MData, MByteEn, MRespAccept,
        input  SCmdAccept, SDataAccept, SResp, SData
    );

    modport slave (
        input  MCmd, MAddr, MData, MByteEn, MRespAccept,
        output SCmdAccept, SDataAccept, SResp, SData
    );
endinterface

// File: rtl/bridge_ram2bus.sv
// Bus master bridge: turns single RAM-style client accesses into non-posted OCP
// transactions, one outstanding, stalling the client until the response arrives.
module bridge_ram2bus #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 0
) (
    input  logic                    Clk,
    input  logic                    MReset_n,
    input  logic                    ram_en,
    input  logic                    ram_we,
    input  logic [ADDR_WIDTH-1:0]   ram_addr,
    input  logic [DATA_WIDTH/8-1:0] ram_be,
    input  logic [DATA_WIDTH-1:0]   ram_data_w,
    output logic [DATA_WIDTH-1:0]   ram_data_r,
    output logic                    ram_delay,
    output logic                    resp_err,
    bridge_ram2bus_if.master        bus
);
    localparam int NUM_BYTES = DATA_WIDTH / 8;
    localparam int CNT_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [2:0] CMD_IDLE  = 3'b000;
    localparam logic [2:0] CMD_WR    = 3'b001;
    localparam logic [2:0] CMD_RD    = 3'b010;
    localparam logic [1:0] RESP_NULL = 2'b00;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_REQ       = 2'd1,
        S_WAIT_RESP = 2'd2
    } state_t;

    state_t                r_state;
    logic [2:0]            r_mcmd;
    logic                  r_resp_accept;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [NUM_BYTES-1:0]  r_be;
    logic [DATA_WIDTH-1:0] r_data;
    logic [DATA_WIDTH-1:0] r_read_reg;
    logic [CNT_W-1:0]      r_cnt;

    logic w_accept;
    logic w_resp_valid;
    logic w_timeout;

    // A write needs command and data accepted in the same cycle.
    assign w_accept     = bus.SCmdAccept && (!r_we || bus.SDataAccept);
    assign w_resp_valid = (bus.SResp != RESP_NULL);
    assign w_timeout    = (TIMEOUT != 0) && !w_resp_valid && (r_cnt == CNT_W'(TIMEOUT - 1));

    assign bus.MCmd        = r_mcmd;
    assign bus.MAddr       = r_addr;
    assign bus.MData       = r_data;
    assign bus.MByteEn     = r_be;
    assign bus.MRespAccept = r_resp_accept;

    always_ff @(posedge Clk) begin
        if (!MReset_n) begin
            r_state       <= S_IDLE;
            r_mcmd        <= CMD_IDLE;
            r_resp_accept <= 1'b0;
            r_we          <= 1'b0;
            r_addr        <= '0;
            r_be          <= '0;
            r_data        <= '0;
            r_read_reg    <= '0;
            r_cnt         <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (ram_en) begin
                        r_we    <= ram_we;
                        r_addr  <= ram_addr;
                        r_be    <= ram_be;
                        r_data  <= ram_data_w;
                        r_mcmd  <= ram_we ? CMD_WR : CMD_RD;
                        r_state <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (w_accept) begin
                        r_mcmd        <= CMD_IDLE;
                        r_resp_accept <= 1'b1;
                        r_cnt         <= '0;
                        r_state       <= S_WAIT_RESP;
                    end
                end
                S_WAIT_RESP: begin
                    if (w_resp_valid) begin
                        r_read_reg    <= bus.SData;
                        r_resp_accept <= 1'b0;
                        r_state       <= S_IDLE;
                    end else if (w_timeout) begin
                        r_resp_accept <= 1'b0;
                        r_state       <= S_IDLE;
                    end else if (r_cnt != '1) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state       <= state_t'('x);
                    r_mcmd        <= 'x;
                    r_resp_accept <= 1'bx;
                end
            endcase
        end
    end

    // Completion is signalled combinationally so the client sees it in the response cycle.
    always_comb begin
        ram_delay  = ram_en;
        ram_data_r = r_read_reg;
        resp_err   = 1'b0;
        case (r_state)
            S_IDLE: begin
                ram_delay = ram_en;
            end
            S_REQ: begin
                ram_delay = 1'b1;
            end
            S_WAIT_RESP: begin
                if (w_resp_valid) begin
                    ram_delay  = 1'b0;
                    ram_data_r = bus.SData;
                    resp_err   = bus.SResp[1];
                end else if (w_timeout) begin
                    ram_delay  = 1'b0;
                    ram_data_r = '0;
                    resp_err   = 1'b1;
                end else begin
                    ram_delay = 1'b1;
                end
            end
            default: begin
                ram_delay  = 1'bx;
                ram_data_r = 'x;
                resp_err   = 1'bx;
            end
        endcase
    end

    a_cmd_stable: assert property (@(posedge Clk) disable iff (!MReset_n)
        (r_state == S_REQ && !w_accept) |=>
            ($stable(bus.MCmd) && $stable(bus.MAddr) && $stable(bus.MData) && $stable(bus.MByteEn)));

    a_en_held: assert property (@(posedge Clk) disable iff (!MReset_n)
        ram_delay |-> ram_en);
endmodule

// File: tb/tb_bridge_ram2bus.sv
// Directed bench for bridge_ram2bus: a TIMEOUT=0 instance for the main scenarios
// and a TIMEOUT=4 instance for forced completion. Inputs change and outputs are sampled at negedge.
module tb_bridge_ram2bus;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NB = DW / 8;

    localparam logic [2:0] CMD_IDLE = 3'b000;
    localparam logic [2:0] CMD_WR   = 3'b001;
    localparam logic [2:0] CMD_RD   = 3'b010;
    localparam logic [1:0] R_NULL   = 2'b00;
    localparam logic [1:0] R_DVA    = 2'b01;
    localparam logic [1:0] R_FAIL   = 2'b10;
    localparam logic [1:0] R_ERR    = 2'b11;

    logic          clk = 1'b0;
    logic          rstN;
    logic          ramEn, ramWe, ramDelay, respErr;
    logic [AW-1:0] ramAddr;
    logic [NB-1:0] ramBe;
    logic [DW-1:0] ramDataW, ramDataR;
    logic          toEn, toWe, toDelay, toErr;
    logic [AW-1:0] toAddr;
    logic [NB-1:0] toBe;
    logic [DW-1:0] toDataW, toDataR;

    int checkCount = 0;
    int errorCount = 0;

    bridge_ram2bus_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) busIf ();
    bridge_ram2bus_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) toIf ();

    bridge_ram2bus #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(0)) dut (
        .Clk(clk), .MReset_n(rstN), .ram_en(ramEn), .ram_we(ramWe), .ram_addr(ramAddr),
        .ram_be(ramBe), .ram_data_w(ramDataW), .ram_data_r(ramDataR), .ram_delay(ramDelay),
        .resp_err(respErr), .bus(busIf)
    );

    bridge_ram2bus #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(4)) dutTo (
        .Clk(clk), .MReset_n(rstN), .ram_en(toEn), .ram_we(toWe), .ram_addr(toAddr),
        .ram_be(toBe), .ram_data_w(toDataW), .ram_data_r(toDataR), .ram_delay(toDelay),
        .resp_err(toErr), .bus(toIf)
    );

    always #5 clk = ~clk;

    task automatic busIdle();
        busIf.SCmdAccept  = 1'b0;
        busIf.SDataAccept = 1'b0;
        busIf.SResp       = R_NULL;
        busIf.SData       = '0;
    endtask

    // Presents a new client request at the next negedge (request cycle 0).
    task automatic applyStimulus(input logic we, input logic [AW-1:0] addr,
                                 input logic [NB-1:0] be, input logic [DW-1:0] data);
        @(negedge clk);
        busIdle();
        ramEn    = 1'b1;
        ramWe    = we;
        ramAddr  = addr;
        ramBe    = be;
        ramDataW = data;
        #1;
    endtask

    task automatic test_reset();
        rstN = 1'b0;
        ramEn = 1'b0; ramWe = 1'b0; ramAddr = '0; ramBe = '0; ramDataW = '0;
        toEn = 1'b0; toWe = 1'b0; toAddr = '0; toBe = '0; toDataW = '0;
        busIdle();
        toIf.SCmdAccept = 1'b0; toIf.SDataAccept = 1'b0; toIf.SResp = R_NULL; toIf.SData = '0;
        repeat (2) @(negedge clk);
        #1;
        checkCount++;
        if ({busIf.MCmd, busIf.MAddr, busIf.MData, busIf.MByteEn, busIf.MRespAccept} !== '0) begin
            errorCount++;
            $display("[TB] FAIL reset_bus: got cmd=%b addr=%h data=%h be=%b racc=%b expected all zero",
                     busIf.MCmd, busIf.MAddr, busIf.MData, busIf.MByteEn, busIf.MRespAccept);
        end
        checkCount++;
        if ({ramDataR, ramDelay, respErr} !== '0) begin
            errorCount++;
            $display("[TB] FAIL reset_client: got data_r=%h delay=%b err=%b expected 0/0/0", ramDataR, ramDelay, respErr);
        end
        ramEn = 1'b1;
        #1;
        checkCount++;
        if (ramDelay !== 1'b1) begin
            errorCount++;
            $display("[TB] FAIL reset_delay_follows_en: got %b expected 1", ramDelay);
        end
        checkCount++;
        if ({toIf.MCmd, toIf.MRespAccept, toDataR, toErr} !== '0) begin
            errorCount++;
            $display("[TB] FAIL reset_to_dut: got cmd=%b racc=%b data_r=%h err=%b expected zeros",
                     toIf.MCmd, toIf.MRespAccept, toDataR, toErr);
        end
        @(negedge clk);
        ramEn = 1'b0;
        rstN  = 1'b1;
    endtask

    task automatic test_read_zero_wait();
        applyStimulus(1'b0, 32'h100, 4'hF, 32'h0);
        checkCount++;
        if ({ramDelay, busIf.MCmd} !== {1'b1, CMD_IDLE}) begin
            errorCount++;
            $display("[TB] FAIL rd_c0: got delay=%b cmd=%b expected 1/000", ramDelay, busIf.MCmd);
        end
        @(negedge clk);
        busIf.SCmdAccept = 1'b1;
        #1;
        checkCount++;
        if ({busIf.MCmd, busIf.MAddr, busIf.MRespAccept, ramDelay} !== {CMD_RD, 32'h100, 1'b0, 1'b1}) begin
            errorCount++;
            $display("[TB] FAIL rd_c1: got cmd=%b addr=%h racc=%b delay=%b expected 010/00000100/0/1",
                     busIf.MCmd, busIf.MAddr, busIf.MRespAccept, ramDelay);
        end
        @(negedge clk);
        busIf.SCmdAccept = 1'b0;
        busIf.SResp = R_DVA;
        busIf.SData = 32'hDEADBEEF;
        #1;
        checkCount++;
        if ({ramDelay, respErr, ramDataR, busIf.MCmd, busIf.MRespAccept} !== {1'b0, 1'b0, 32'hDEADBEEF, CMD_IDLE, 1'b1}) begin
            errorCount++;
            $display("[TB] FAIL rd_c2: got delay=%b err=%b data_r=%h cmd=%b racc=%b expected 0/0/deadbeef/000/1",
                     ramDelay, respErr, ramDataR, busIf.MCmd, busIf.MRespAccept);
        end
        @(negedge clk);
        busIdle();
        ramEn = 1'b0;
        #1;
        checkCount++;
        if ({ramDataR, ramDelay, busIf.MRespAccept} !== {32'hDEADBEEF, 1'b0, 1'b0}) begin
            errorCount++;
            $display("[TB] FAIL rd_hold: got data_r=%h delay=%b racc=%b expected deadbeef/0/0", ramDataR, ramDelay, busIf.MRespAccept);
        end
    endtask

    task automatic test_write_stall();
        applyStimulus(1'b1, 32'h20, 4'b0011, 32'h12345678);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            busIf.SCmdAccept  = 1'b1;
            busIf.SDataAccept = (i == 3);
            ramDataW = (i == 1) ? 32'hFFFFFFFF : 32'h12345678;
            #1;
            checkCount++;
            if ({busIf.MCmd, busIf.MAddr, busIf.MData, busIf.MByteEn, ramDelay, busIf.MRespAccept}
                    !== {CMD_WR, 32'h20, 32'h12345678, 4'b0011, 1'b1, 1'b0}) begin
                errorCount++;
                $display("[TB] FAIL wr_stall_%0d: got cmd=%b addr=%h data=%h be=%b delay=%b racc=%b expected 001/20/12345678/0011/1/0",
                         i, busIf.MCmd, busIf.MAddr, busIf.MData, busIf.MByteEn, ramDelay, busIf.MRespAccept);
            end
        end
        @(negedge clk);
        busIdle();
        busIf.SResp = R_DVA;
        busIf.SData = 32'hCAFE0001;
        #1;
        checkCount++;
        if ({ramDelay, respErr, ramDataR, busIf.MCmd} !== {1'b0, 1'b0, 32'hCAFE0001, CMD_IDLE}) begin
            errorCount++;
            $display("[TB] FAIL wr_done: got delay=%b err=%b data_r=%h cmd=%b expected 0/0/cafe0001/000",
                     ramDelay, respErr, ramDataR, busIf.MCmd);
        end
        @(negedge clk);
        busIdle();
        ramEn = 1'b0;
    endtask

    task automatic test_slow_resp();
        applyStimulus(1'b0, 32'h40, 4'hF, 32'h0);
        @(negedge clk);
        busIf.SCmdAccept = 1'b1;
        #1;
        checkCount++;
        if (busIf.MRespAccept !== 1'b0) begin
            errorCount++;
            $display("[TB] FAIL slow_req_racc: got %b expected 0", busIf.MRespAccept);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            busIdle();
            #1;
            checkCount++;
            if ({busIf.MRespAccept, ramDelay, respErr, busIf.MCmd} !== {1'b1, 1'b1, 1'b0, CMD_IDLE}) begin
                errorCount++;
                $display("[TB] FAIL slow_wait_%0d: got racc=%b delay=%b err=%b cmd=%b expected 1/1/0/000",
                         i, busIf.MRespAccept, ramDelay, respErr, busIf.MCmd);
            end
        end
        @(negedge clk);
        busIf.SResp = R_DVA;
        busIf.SData = 32'hA5A50F0F;
        #1;
        checkCount++;
        if ({busIf.MRespAccept, ramDelay, ramDataR} !== {1'b1, 1'b0, 32'hA5A50F0F}) begin
            errorCount++;
            $display("[TB] FAIL slow_done: got racc=%b delay=%b data_r=%h expected 1/0/a5a50f0f",
                     busIf.MRespAccept, ramDelay, ramDataR);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            busIdle();
            busIf.SData = 32'h0BADF00D;
            ramEn = 1'b0;
            #1;
            checkCount++;
            if ({ramDataR, ramDelay, busIf.MRespAccept} !== {32'hA5A50F0F, 1'b0, 1'b0}) begin
                errorCount++;
                $display("[TB] FAIL slow_hold_%0d: got data_r=%h delay=%b racc=%b expected a5a50f0f/0/0",
                         i, ramDataR, ramDelay, busIf.MRespAccept);
            end
        end
    endtask

    task automatic test_err_resp();
        logic [1:0]  respCode [3] = '{R_ERR, R_DVA, R_FAIL};
        logic        expErr   [3] = '{1'b1, 1'b0, 1'b1};
        logic [DW-1:0] rdData [3] = '{32'h0BAD0BAD, 32'h600D600D, 32'h0FA110FA};
        for (int t = 0; t < 3; t++) begin
            applyStimulus(t == 1, 32'h80 + 32'(t * 4), 4'hF, 32'h55AA55AA);
            @(negedge clk);
            busIf.SCmdAccept  = 1'b1;
            busIf.SDataAccept = 1'b1;
            #1;
            checkCount++;
            if ({busIf.MCmd, busIf.MAddr} !== {(t == 1) ? CMD_WR : CMD_RD, 32'h80 + 32'(t * 4)}) begin
                errorCount++;
                $display("[TB] FAIL err_cmd_%0d: got cmd=%b addr=%h expected cmd for we=%0d addr=%h",
                         t, busIf.MCmd, busIf.MAddr, t == 1, 32'h80 + 32'(t * 4));
            end
            @(negedge clk);
            busIdle();
            busIf.SResp = respCode[t];
            busIf.SData = rdData[t];
            #1;
            checkCount++;
            if ({respErr, ramDelay, ramDataR} !== {expErr[t], 1'b0, rdData[t]}) begin
                errorCount++;
                $display("[TB] FAIL err_done_%0d: got err=%b delay=%b data_r=%h expected %b/0/%h",
                         t, respErr, ramDelay, ramDataR, expErr[t], rdData[t]);
            end
            @(negedge clk);
            busIdle();
            ramEn = 1'b0;
            #1;
            checkCount++;
            if ({respErr, busIf.MCmd, busIf.MRespAccept} !== {1'b0, CMD_IDLE, 1'b0}) begin
                errorCount++;
                $display("[TB] FAIL err_pulse_%0d: got err=%b cmd=%b racc=%b expected 0/000/0",
                         t, respErr, busIf.MCmd, busIf.MRespAccept);
            end
        end
    endtask

    task automatic test_back_to_back();
        applyStimulus(1'b0, 32'h600, 4'hF, 32'h0);
        @(negedge clk);
        busIf.SCmdAccept = 1'b1;
        @(negedge clk);
        busIdle();
        busIf.SResp = R_DVA;
        busIf.SData = 32'h11111111;
        #1;
        checkCount++;
        if ({ramDelay, ramDataR} !== {1'b0, 32'h11111111}) begin
            errorCount++;
            $display("[TB] FAIL b2b_first: got delay=%b data_r=%h expected 0/11111111", ramDelay, ramDataR);
        end
        applyStimulus(1'b0, 32'h604, 4'hF, 32'h0);
        checkCount++;
        if ({ramDelay, ramDataR, busIf.MCmd} !== {1'b1, 32'h11111111, CMD_IDLE}) begin
            errorCount++;
            $display("[TB] FAIL b2b_idle: got delay=%b data_r=%h cmd=%b expected 1/11111111/000", ramDelay, ramDataR, busIf.MCmd);
        end
        @(negedge clk);
        busIf.SCmdAccept = 1'b1;
        #1;
        checkCount++;
        if ({busIf.MCmd, busIf.MAddr} !== {CMD_RD, 32'h604}) begin
            errorCount++;
            $display("[TB] FAIL b2b_cmd: got cmd=%b addr=%h expected 010/00000604", busIf.MCmd, busIf.MAddr);
        end
        @(negedge clk);
        busIdle();
        busIf.SResp = R_DVA;
        busIf.SData = 32'h22222222;
        #1;
        checkCount++;
        if ({ramDelay, ramDataR, respErr} !== {1'b0, 32'h22222222, 1'b0}) begin
            errorCount++;
            $display("[TB] FAIL b2b_second: got delay=%b data_r=%h err=%b expected 0/22222222/0", ramDelay, ramDataR, respErr);
        end
        @(negedge clk);
        busIdle();
        ramEn = 1'b0;
    endtask

    task automatic test_timeout();
        @(negedge clk);
        toEn = 1'b1; toWe = 1'b0; toAddr = 32'h300; toBe = 4'hF;
        @(negedge clk);
        toIf.SCmdAccept = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            toIf.SCmdAccept = 1'b0;
            toIf.SData = 32'h00001234;
            #1;
            checkCount++;
            if ({toDelay, toErr, toIf.MRespAccept} !== {1'b1, 1'b0, 1'b1}) begin
                errorCount++;
                $display("[TB] FAIL to_wait_%0d: got delay=%b err=%b racc=%b expected 1/0/1", i, toDelay, toErr, toIf.MRespAccept);
            end
        end
        @(negedge clk);
        #1;
        checkCount++;
        if ({toDelay, toDataR, toErr} !== {1'b0, 32'h0, 1'b1}) begin
            errorCount++;
            $display("[TB] FAIL to_forced: got delay=%b data_r=%h err=%b expected 0/00000000/1", toDelay, toDataR, toErr);
        end
        @(negedge clk);
        toEn = 1'b0;
        #1;
        checkCount++;
        if ({toIf.MCmd, toIf.MRespAccept, toErr, toDelay} !== {CMD_IDLE, 1'b0, 1'b0, 1'b0}) begin
            errorCount++;
            $display("[TB] FAIL to_after: got cmd=%b racc=%b err=%b delay=%b expected 000/0/0/0",
                     toIf.MCmd, toIf.MRespAccept, toErr, toDelay);
        end
    endtask

    task automatic test_reset_mid();
        applyStimulus(1'b0, 32'h400, 4'hF, 32'h0);
        @(negedge clk);
        busIf.SCmdAccept = 1'b1;
        @(negedge clk);
        busIdle();
        rstN = 1'b0;
        #1;
        checkCount++;
        if ({busIf.MRespAccept, ramDelay} !== {1'b1, 1'b1}) begin
            errorCount++;
            $display("[TB] FAIL rst_mid_wait: got racc=%b delay=%b expected 1/1", busIf.MRespAccept, ramDelay);
        end
        @(negedge clk);
        rstN  = 1'b1;
        ramEn = 1'b0;
        busIf.SResp = R_DVA;
        busIf.SData = 32'h77777777;
        #1;
        checkCount++;
        if ({busIf.MCmd, busIf.MRespAccept, ramDataR, ramDelay, respErr} !== {CMD_IDLE, 1'b0, 32'h0, 1'b0, 1'b0}) begin
            errorCount++;
            $display("[TB] FAIL rst_mid_after: got cmd=%b racc=%b data_r=%h delay=%b err=%b expected 000/0/0/0/0",
                     busIf.MCmd, busIf.MRespAccept, ramDataR, ramDelay, respErr);
        end
        @(negedge clk);
        busIdle();
        #1;
        checkCount++;
        if (ramDataR !== 32'h0) begin
            errorCount++;
            $display("[TB] FAIL rst_mid_stale_dva: got data_r=%h expected 00000000", ramDataR);
        end
        applyStimulus(1'b0, 32'h500, 4'hF, 32'h0);
        @(negedge clk);
        busIf.SCmdAccept = 1'b1;
        #1;
        checkCount++;
        if ({busIf.MCmd, busIf.MAddr} !== {CMD_RD, 32'h500}) begin
            errorCount++;
            $display("[TB] FAIL rst_mid_next_cmd: got cmd=%b addr=%h expected 010/00000500", busIf.MCmd, busIf.MAddr);
        end
        @(negedge clk);
        busIdle();
        busIf.SResp = R_DVA;
        busIf.SData = 32'h5A5A5A5A;
        #1;
        checkCount++;
        if ({ramDelay, ramDataR, respErr} !== {1'b0, 32'h5A5A5A5A, 1'b0}) begin
            errorCount++;
            $display("[TB] FAIL rst_mid_next_done: got delay=%b data_r=%h err=%b expected 0/5a5a5a5a/0", ramDelay, ramDataR, respErr);
        end
        @(negedge clk);
        busIdle();
        ramEn = 1'b0;
    endtask

    initial begin
        test_reset();
        test_read_zero_wait();
        test_write_stall();
        test_slow_resp();
        test_err_resp();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time limit reached after %0d checks", checkCount);
        $fatal(1, "[TB] simulation did not terminate");
    end
endmodule
